// File: rtl/mxn_logic_sequencer.sv
// mxn_logic_sequencer
//   Handshaked front-end for the mXnBit logic gate bank. Captures a packed
//   SETS x WIDTH operand pair plus a 3-bit logic opcode, evaluates one lane
//   per cycle, then holds the packed result and per-lane zero flags until
//   the downstream stage accepts them.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : upstream handshake (op, in1_packed, in2_packed)
//   out_valid/out_ready : downstream handshake (out_packed, zero_flags)
//   busy              : high while an operation is in flight or held
//   txn_count         : results accepted downstream (wraps)
//
// Opcodes: 000 NOT A, 001 AND, 010 OR, 011 NAND, 100 NOR, 101 XOR,
//          110 XNOR, 111 PASS A
//
// state | meaning
// IDLE  | ready for a new operation; last result still visible
// PROC  | evaluating lane idx_q, one lane per cycle
// DONE  | result valid, waiting for out_ready

module mxn_logic_sequencer #(
  parameter int WIDTH = 4,
  parameter int SETS  = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [SETS*WIDTH-1:0] in1_packed,
  input  logic [SETS*WIDTH-1:0] in2_packed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SETS*WIDTH-1:0] out_packed,
  output logic [SETS-1:0]       zero_flags,
  output logic                  busy,
  output logic [CNT_W-1:0]      txn_count
);

  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [SETS*WIDTH-1:0]   in1_q, in1_d;
  logic [SETS*WIDTH-1:0]   in2_q, in2_d;
  logic [SETS*WIDTH-1:0]   out_q, out_d;
  logic [SETS-1:0]         zf_q, zf_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [WIDTH-1:0]        lane_a;
  logic [WIDTH-1:0]        lane_b;
  logic [WIDTH-1:0]        lane_res;

  // Operand lane selected by the current lane index.
  always_comb begin
    lane_a = in1_q[int'(idx_q)*WIDTH +: WIDTH];
    lane_b = in2_q[int'(idx_q)*WIDTH +: WIDTH];
    case (op_q)
      3'b000:  lane_res = ~lane_a;
      3'b001:  lane_res = lane_a & lane_b;
      3'b010:  lane_res = lane_a | lane_b;
      3'b011:  lane_res = ~(lane_a & lane_b);
      3'b100:  lane_res = ~(lane_a | lane_b);
      3'b101:  lane_res = lane_a ^ lane_b;
      3'b110:  lane_res = ~(lane_a ^ lane_b);
      default: lane_res = lane_a;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    out_d   = out_q;
    zf_d    = zf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          in1_d   = in1_packed;
          in2_d   = in2_packed;
          out_d   = '0;
          zf_d    = '0;
          idx_d   = '0;
          state_d = PROC;
        end
      end
      PROC: begin
        out_d[int'(idx_q)*WIDTH +: WIDTH] = lane_res;
        zf_d[idx_q] = (lane_res == '0);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      out_q   <= '0;
      zf_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      out_q   <= out_d;
      zf_q    <= zf_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_packed = out_q;
  assign zero_flags = zf_q;
  assign txn_count  = cnt_q;

endmodule

// File: tb/tb_mxn_logic_sequencer.sv
// Bench for mxn_logic_sequencer (WIDTH=4, SETS=2, CNT_W=8): directed cases,
// full opcode x lane-value sweep and randomized traffic against a
// whole-vector reference model.

module tb_mxn_logic_sequencer;

  localparam int WIDTH = 4;
  localparam int SETS  = 2;
  localparam int CNT_W = 8;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [SETS*WIDTH-1:0] in1_packed;
  logic [SETS*WIDTH-1:0] in2_packed;
  logic                  out_valid;
  logic                  out_ready;
  logic [SETS*WIDTH-1:0] out_packed;
  logic [SETS-1:0]       zero_flags;
  logic                  busy;
  logic [CNT_W-1:0]      txn_count;

  int n_checks;
  int n_errors;
  logic [CNT_W-1:0] exp_cnt;

  mxn_logic_sequencer #(.WIDTH(WIDTH), .SETS(SETS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .in1_packed (in1_packed),
    .in2_packed (in2_packed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_packed (out_packed),
    .zero_flags (zero_flags),
    .busy       (busy),
    .txn_count  (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bitwise ops on whole packed vectors: lanes are independent, so no
  // per-lane iteration is needed for the result itself.
  function automatic logic [SETS*WIDTH-1:0] model(input logic [2:0] o,
                                                 input logic [SETS*WIDTH-1:0] a,
                                                 input logic [SETS*WIDTH-1:0] b);
    case (o)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  function automatic logic [SETS-1:0] model_zf(input logic [SETS*WIDTH-1:0] r);
    logic [SETS-1:0] z;
    for (int i = 0; i < SETS; i++) z[i] = (r[i*WIDTH +: WIDTH] == '0);
    return z;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept, wait for result, hold for `hold` cycles, then hand it off.
  task automatic do_op(input logic [2:0] o, input logic [SETS*WIDTH-1:0] a,
                       input logic [SETS*WIDTH-1:0] b, input int hold);
    logic [SETS*WIDTH-1:0] e;
    logic [SETS-1:0]       ez;
    int lat;
    e  = model(o, a, b);
    ez = model_zf(e);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    op = o; in1_packed = a; in2_packed = b; in_valid = 1'b1;
    tick();
    in_valid   = 1'b0;
    op         = 3'($urandom);
    in1_packed = 8'($urandom);
    in2_packed = 8'($urandom);
    check("cleared_on_accept", 32'({zero_flags, out_packed}), 32'd0);
    check("busy_proc", 32'({busy, in_ready}), 32'b10);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(SETS));
    check("out_packed", 32'(out_packed), 32'(e));
    check("zero_flags", 32'(zero_flags), 32'(ez));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_valid", 32'({out_valid, in_ready}), 32'b10);
      check("hold_data", 32'(out_packed), 32'(e));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt   = exp_cnt + 1'b1;
    check("post_hs", 32'({out_valid, in_ready, busy}), 32'b010);
    check("txn_count", 32'(txn_count), 32'(exp_cnt));
    check("kept_result", 32'(out_packed), 32'(e));
  endtask

  task automatic check_reset_state(input string tag);
    check(tag, 32'({out_valid, in_ready, busy, zero_flags, out_packed, txn_count}),
          32'({1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00}));
  endtask

  initial begin
    n_checks = 0; n_errors = 0; exp_cnt = '0;
    rst = 1'b1; in_valid = 1'b0; op = '0; in1_packed = '0; in2_packed = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    check_reset_state("reset_state");
    rst = 1'b0;
    tick();

    // Directed cases
    do_op(3'b001, 8'hA5, 8'h3C, 0);     // AND -> 0x24
    do_op(3'b000, 8'hF0, 8'h00, 0);     // NOT -> 0x0F, flags 10
    do_op(3'b101, 8'hA5, 8'h3C, 0);     // XOR -> 0x99
    do_op(3'b011, 8'hFF, 8'h0F, 5);     // NAND with backpressure
    do_op(3'b010, 8'h11, 8'h22, 0);     // OR, inputs scrambled during PROC
    do_op(3'b111, 8'h00, 8'hFF, 0);     // PASS A -> both lanes zero

    // Reset in the first PROC cycle
    op = 3'b001; in1_packed = 8'hFF; in2_packed = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = '0;
    check_reset_state("reset_mid_proc");
    do_op(3'b110, 8'h0F, 8'h0F, 0);     // XNOR -> 0xFF

    // Reset in DONE while out_ready is high: reset wins, count stays 0
    op = 3'b010; in1_packed = 8'h12; in2_packed = 8'h34; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (SETS) tick();
    check("reached_done", 32'(out_valid), 32'd1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    exp_cnt = '0;
    check_reset_state("reset_in_done");

    // Exhaustive sweep: 8 ops x 16 x 16, same lane value in both lanes
    for (int o = 0; o < 8; o++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          do_op(3'(o), {4'(a), 4'(a)}, {4'(b), 4'(b)}, 0);
    check("count_wrapped", 32'(txn_count), 32'd0);

    // Randomized traffic with random idle gaps and backpressure
    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 2)) tick();
      do_op(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
